// File: rtl/axis_step_generator.sv
// axis_step_generator: trapezoidal step/direction pulse generator for one motor axis.
// A motion accelerates from period t0 towards cruise period tna, cruises, then mirrors
// the acceleration ramp to decelerate. Every period is clamped to at least MIN_PERIOD.
// Optional feature: define ENDSTOP_ABORT_EN to add an endstop input that aborts a run.
module axis_step_generator #(
   parameter int unsigned PULSE_W    = 10,
   parameter int unsigned MIN_PERIOD = 2 * PULSE_W
) (
   input  logic               clk,
   input  logic               reset,
`ifdef ENDSTOP_ABORT_EN
   input  logic               endstop,
`endif
   input  logic               start,
   input  logic signed [31:0] num,
   input  logic        [31:0] params [0:4],
   output logic               step,
   output logic               dir,
   output logic               busy,
   output logic               finish
);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } state_t;

   localparam logic [31:0] PULSE_LEN = 32'(PULSE_W);
   localparam logic [31:0] MIN_LEN   = 32'(MIN_PERIOD);

   state_t      state;
   state_t      next_state;

   logic        start_q;
   logic        start_rise;
   logic        abort;

   logic [31:0] n_reg;
   logic [31:0] tna_reg;
   logic [31:0] delta_reg;
   logic [31:0] nn_eff_reg;
   logic        dir_reg;

   logic [31:0] idx;
   logic [31:0] idx_next;
   logic [31:0] cnt;
   logic [31:0] cnt_next;
   logic [31:0] ramp;
   logic [31:0] sat_cnt;

   logic [31:0] half_n;
   logic [31:0] nn_eff_load;
   logic [31:0] decel_start;
   logic        in_ramp;
   logic [31:0] ramp_eff;
   logic [31:0] shaped;
   logic [31:0] period;
   logic        period_end;
   logic        last_step;
   logic        ramp_down;
   logic        ramp_up;
   logic        step_next;

   // The edge detector powers up as "start already seen", so a start held high
   // through reset must drop and rise again before a motion begins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b1;
      end else begin
         start_q <= start;
      end
   end

   assign start_rise = start & ~start_q;

`ifdef ENDSTOP_ABORT_EN
   logic [1:0] endstop_sync;

   // Two-flop synchroniser for the asynchronous endstop switch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         endstop_sync <= 2'b00;
      end else begin
         endstop_sync <= {endstop_sync[0], endstop};
      end
   end

   assign abort = endstop_sync[1];
`else
   assign abort = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Ramp length limited to half the move so accel and decel never overlap.
   always_comb begin
      half_n      = params[0] >> 1;
      nn_eff_load = (params[1] < half_n) ? params[1] : half_n;
   end

   // Period of the current step: ramp value floored at tna in the ramp phases,
   // tna while cruising, then never shorter than MIN_LEN.
   always_comb begin
      decel_start = n_reg - nn_eff_reg;
      in_ramp     = (idx < nn_eff_reg) || (idx >= decel_start);
      ramp_eff    = (sat_cnt != 32'd0) ? 32'd0 : ramp;
      shaped      = tna_reg;
      if (in_ramp && (ramp_eff > tna_reg)) begin
         shaped = ramp_eff;
      end
      period     = (shaped < MIN_LEN) ? MIN_LEN : shaped;
      period_end = ((cnt + 32'd1) >= period);
      last_step  = (idx == (n_reg - 32'd1));
      idx_next   = idx + 32'd1;
      ramp_down  = (idx_next < nn_eff_reg);
      ramp_up    = (idx_next > decel_start);
   end

   // Next-state and cycle-counter logic; the step pulse is decoded from the
   // values the counters will hold after this edge so it can be registered.
   always_comb begin
      next_state = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (start_rise) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            cnt_next = 32'd0;
            if (params[0] == 32'd0) begin
               next_state = DONE;
            end else begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               next_state = DONE;
            end else if (period_end) begin
               cnt_next = 32'd0;
               if (last_step) begin
                  next_state = DONE;
               end
            end else begin
               cnt_next = cnt + 32'd1;
            end
         end
         DONE: begin
            if (!start) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      step_next = (next_state == RUN) && (cnt_next < PULSE_LEN);
   end

   // Motion parameters and direction are captured once in LOAD and held for the move.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n_reg      <= 32'd0;
         tna_reg    <= 32'd0;
         delta_reg  <= 32'd0;
         nn_eff_reg <= 32'd0;
         dir_reg    <= 1'b0;
      end else if (state == LOAD) begin
         n_reg      <= params[0];
         tna_reg    <= params[3];
         delta_reg  <= params[4];
         nn_eff_reg <= nn_eff_load;
         dir_reg    <= (num >= 32'sd0);
      end
   end

   // Step index and ramp tracking. The ramp walks down by delta during accel and
   // back up during decel; sat_cnt counts how many steps the ideal value sits
   // below zero so the climb back up retraces exactly the same values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= 32'd0;
         cnt     <= 32'd0;
         ramp    <= 32'd0;
         sat_cnt <= 32'd0;
      end else begin
         cnt <= cnt_next;
         if (state == LOAD) begin
            idx     <= 32'd0;
            ramp    <= params[2];
            sat_cnt <= 32'd0;
         end else if ((state == RUN) && !abort && period_end && !last_step) begin
            idx <= idx_next;
            if (ramp_down) begin
               if ((sat_cnt != 32'd0) || (ramp < delta_reg)) begin
                  sat_cnt <= sat_cnt + 32'd1;
               end else begin
                  ramp <= ramp - delta_reg;
               end
            end else if (ramp_up) begin
               if (sat_cnt != 32'd0) begin
                  sat_cnt <= sat_cnt - 32'd1;
               end else begin
                  ramp <= ramp + delta_reg;
               end
            end
         end
      end
   end

   // Registered step output so the driver never sees decode glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step <= 1'b0;
      end else begin
         step <= step_next;
      end
   end

   assign dir    = dir_reg;
   assign busy   = (state == LOAD) || (state == RUN);
   assign finish = (state == DONE);

endmodule

// File: tb/tb_axis_step_generator.sv
// tb_axis_step_generator: scoreboard bench for axis_step_generator.
// Expected step periods come from a closed-form model of the ramp profile and are
// queued when a motion is launched; a monitor pops them on each step rising edge.
module tb_axis_step_generator;

   localparam int PULSE_W    = 10;
   localparam int MIN_PERIOD = 20;

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic signed [31:0] num;
   logic        [31:0] params [0:4];
   logic               step;
   logic               dir;
   logic               busy;
   logic               finish;
`ifdef ENDSTOP_ABORT_EN
   logic               endstop;
`endif

   axis_step_generator #(
      .PULSE_W   (PULSE_W),
      .MIN_PERIOD(MIN_PERIOD)
   ) dut (
      .clk    (clk),
      .reset  (reset),
`ifdef ENDSTOP_ABORT_EN
      .endstop(endstop),
`endif
      .start  (start),
      .num    (num),
      .params (params),
      .step   (step),
      .dir    (dir),
      .busy   (busy),
      .finish (finish)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   int     check_count = 0;
   int     pass_count  = 0;
   int     exp_q[$];
   int     cyc         = 0;
   int     last_rise   = 0;
   int     high_len    = 0;
   int     pulse_count = 0;
   int     busy_cycles = 0;
   bit     have_rise   = 1'b0;
   bit     prev_step   = 1'b0;
   bit     prev_finish = 1'b0;
   bit     sb_en       = 1'b1;
   logic   exp_dir     = 1'b0;
   longint exp_total   = 0;

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      check_count++;
      if (observed == expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Closed-form reference period for step i of an n-step move.
   function automatic longint expPeriod(longint i, longint n, longint nn, longint t0,
                                        longint tna, longint delta);
      longint nn_eff;
      longint raw;
      nn_eff = (nn < (n / 2)) ? nn : (n / 2);
      if (i < nn_eff) begin
         raw = t0 - i * delta;
      end else if (i >= n - nn_eff) begin
         raw = t0 - (n - 1 - i) * delta;
      end else begin
         raw = tna;
      end
      if (raw < 0) raw = 0;
      if (raw < tna) raw = tna;
      if (raw < MIN_PERIOD) raw = MIN_PERIOD;
      return raw;
   endfunction

   // Monitor: measures rising-edge spacing, pulse width and the final period
   // (last rising edge to finish) and compares them against the scoreboard.
   always @(negedge clk) begin
      int exp_v;
      cyc++;
      if (reset) begin
         prev_step   = 1'b0;
         prev_finish = 1'b0;
         have_rise   = 1'b0;
         high_len    = 0;
      end else begin
         if (busy) busy_cycles++;
         if (step && !prev_step) begin
            pulse_count++;
            if (have_rise && sb_en) begin
               if (exp_q.size() > 0) begin
                  exp_v = exp_q.pop_front();
                  checkOutput("spacing", cyc - last_rise, exp_v);
               end else begin
                  checkOutput("unexpected_pulse", cyc - last_rise, 0);
               end
            end
            have_rise = 1'b1;
            last_rise = cyc;
            high_len  = 1;
         end else if (step) begin
            high_len++;
         end else if (prev_step) begin
            checkOutput("pulse_width", high_len, PULSE_W);
         end
         if (finish && !prev_finish && have_rise && sb_en) begin
            if (exp_q.size() > 0) begin
               exp_v = exp_q.pop_front();
               checkOutput("last_period", cyc - last_rise, exp_v);
            end else begin
               checkOutput("finish_extra", cyc - last_rise, 0);
            end
         end
         prev_step   = step;
         prev_finish = finish;
      end
   end

   task automatic applyStimulus(input int num_v, input int n, input int nn, input int t0,
                                input int tna, input int delta);
      longint p;
      @(posedge clk); #1;
      start     = 1'b0;
      num       = num_v;
      params[0] = n;
      params[1] = nn;
      params[2] = t0;
      params[3] = tna;
      params[4] = delta;
      exp_dir   = (num_v >= 0);
      exp_total = 0;
      for (int i = 0; i < n; i++) begin
         p = expPeriod(i, n, nn, t0, tna, delta);
         exp_q.push_back(int'(p));
         exp_total += p;
      end
      have_rise   = 1'b0;
      pulse_count = 0;
      busy_cycles = 0;
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
   endtask

   task automatic waitFinish(input longint limit);
      longint c = 0;
      while (!finish && c < limit) begin
         @(negedge clk); #1;
         c++;
      end
      checkOutput("finish_reached", finish, 1);
   endtask

   task automatic endMotion();
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      checkOutput("finish_cleared", finish, 0);
   endtask

   task automatic checkMotion(input int n, input bit check_busy);
      waitFinish(exp_total + 50);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("finish_held", finish, 1);
      checkOutput("busy_done", busy, 0);
      checkOutput("pulse_count", pulse_count, n);
      checkOutput("dir", dir, exp_dir);
      checkOutput("queue_empty", exp_q.size(), 0);
      if (check_busy) checkOutput("busy_cycles", busy_cycles, exp_total + 1);
      endMotion();
   endtask

   // Test sequence.
   initial begin
      int c;
      reset = 1'b1;
      start = 1'b0;
      num   = 0;
      for (int i = 0; i < 5; i++) params[i] = 32'd0;
`ifdef ENDSTOP_ABORT_EN
      endstop = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_step", step, 0);
      checkOutput("reset_dir", dir, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_finish", finish, 0);
      reset = 1'b0;

      // Symmetric ramp; inputs scrambled and start re-pulsed mid-run.
      applyStimulus(6, 6, 2, 100, 60, 20);
      repeat (150) @(posedge clk);
      #1;
      num       = -1;
      params[0] = 3;
      params[2] = 500;
      params[3] = 25;
      params[4] = 7;
      start     = 1'b0;
      repeat (5) @(posedge clk);
      #1 start = 1'b1;
      checkMotion(6, 1'b1);

      // Negative direction, accel steps limited to half the move.
      applyStimulus(-5, 5, 3, 100, 60, 20);
      checkMotion(5, 1'b1);

      // Zero-length move: LOAD then straight to DONE.
      applyStimulus(3, 0, 2, 100, 60, 20);
      @(negedge clk); #1;
      checkOutput("n0_busy_early", busy, 0);
      @(negedge clk); #1;
      checkOutput("n0_busy_load", busy, 1);
      checkOutput("n0_finish_early", finish, 0);
      @(negedge clk); #1;
      checkOutput("n0_finish", finish, 1);
      checkMotion(0, 1'b1);

      // Short periods clamped up to MIN_PERIOD.
      applyStimulus(3, 3, 1, 5, 5, 0);
      checkMotion(3, 1'b1);

      // Ramp that underflows past zero; decel must mirror it exactly.
      applyStimulus(8, 8, 4, 50, 0, 30);
      checkMotion(8, 1'b1);

      // Longer move with a cruise section.
      applyStimulus(20, 20, 8, 200, 40, 15);
      checkMotion(20, 1'b1);

      // Reset during the third pulse, start held high across it.
      applyStimulus(6, 6, 2, 100, 60, 20);
      c = 0;
      while (pulse_count < 3 && c < 1000) begin
         @(negedge clk); #1;
         c++;
      end
      checkOutput("third_pulse_seen", pulse_count, 3);
      checkOutput("third_pulse_high", step, 1);
      #1 reset = 1'b1;
      #1;
      checkOutput("rst_step", step, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_finish", finish, 0);
      checkOutput("rst_dir", dir, 0);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (100) @(negedge clk);
      #1;
      checkOutput("rst_no_motion_pulses", pulse_count, 3);
      checkOutput("rst_no_motion_busy", busy, 0);
      checkOutput("rst_no_motion_finish", finish, 0);

      // Fresh start edge after reset gives a normal move.
      applyStimulus(-4, 4, 1, 90, 50, 25);
      checkMotion(4, 1'b1);

`ifdef ENDSTOP_ABORT_EN
      // Endstop hit during a long move aborts within three cycles.
      sb_en = 1'b0;
      applyStimulus(1000, 1000, 0, 30, 30, 0);
      exp_q.delete();
      c = 0;
      while (pulse_count < 10 && c < 2000) begin
         @(negedge clk); #1;
         c++;
      end
      checkOutput("endstop_pulse10", pulse_count, 10);
      c = 0;
      while (step && c < 100) begin
         @(negedge clk); #1;
         c++;
      end
      endstop = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("endstop_finish", finish, 1);
      checkOutput("endstop_step", step, 0);
      repeat (100) @(negedge clk);
      #1;
      checkOutput("endstop_no_more_pulses", pulse_count, 10);
      checkOutput("endstop_finish_held", finish, 1);
      endstop = 1'b0;
      endMotion();
      sb_en = 1'b1;
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/axis_step_generator.md
AXIS_STEP_GENERATOR -- requirements
Module: axis_step_generator

Interface
REQ-001 Parameter PULSE_W, default 10: STEP high time in clk cycles; legal range 1..255.
REQ-002 Parameter MIN_PERIOD, default 2*PULSE_W: smallest step period in clk cycles that the block will emit.
REQ-003 Port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: level request; a motion starts on its rising edge while IDLE.
REQ-006 Port num, input, signed 32 bits: signed step count; only the sign is used, to set direction.
REQ-007 Port params, input, array [0:4] of 32 bits: [0]=N total steps, [1]=nn accel steps, [2]=t0 initial period, [3]=tna cruise period, [4]=delta period change per step.
REQ-008 Port step, output, 1 bit: step pulse to the driver.
REQ-009 Port dir, output, 1 bit: 1 when num >= 0, 0 when num < 0.
REQ-010 Port busy, output, 1 bit: high while a motion is in progress.
REQ-011 Port finish, output, 1 bit: motion complete flag.
REQ-012 Port endstop, input, 1 bit: present only when ENDSTOP_ABORT_EN is defined.

Function
REQ-013 States: IDLE, LOAD, RUN, DONE.
REQ-014 IDLE -> LOAD on a start rising edge; IDLE ignores start held high without a new edge.
REQ-015 LOAD lasts one cycle: latch all params and dir; compute nn_eff = min(nn, N>>1); clear the step index.
REQ-016 LOAD -> DONE directly when N == 0; no step is emitted.
REQ-017 LOAD -> RUN otherwise; the first step rises on the cycle after LOAD.
REQ-018 Each step period (index i, 0..N-1) starts with step high for PULSE_W cycles, then step low for the rest of the period.
REQ-019 Accel phase, i < nn_eff: period = max(t0 - i*delta, tna).
REQ-020 Cruise phase, nn_eff <= i < N-nn_eff: period = tna.
REQ-021 Decel phase, i >= N-nn_eff: period = max(t0 - (N-1-i)*delta, tna).
REQ-022 Each period is then clamped to >= MIN_PERIOD.
REQ-023 Period arithmetic is unsigned 32-bit; subtraction saturates at 0 before the max() and clamp, so underflow never wraps.
REQ-024 Periods are updated incrementally (add or subtract delta per step); no multiplier.
REQ-025 RUN -> DONE at the end of the low time of step N-1.
REQ-026 DONE: finish=1, busy=0; stays until start is low; then -> IDLE with finish=0.
REQ-027 busy = 1 in LOAD and RUN, 0 otherwise.
REQ-028 dir is stable from LOAD until the next LOAD.
REQ-029 params and num changes during RUN are ignored.
REQ-030 A start edge during RUN or DONE is ignored.

Reset
REQ-031 reset asserted, at any time including mid-pulse: state=IDLE, step=0, dir=0, busy=0, finish=0; all counters and latched params cleared.
REQ-032 After reset release, a new motion requires a fresh start rising edge.

Configuration
REQ-033 Macro ENDSTOP_ABORT_EN defined: the endstop port exists; endstop, synchronised through 2 flops, high in RUN forces step=0 within 3 cycles and moves to DONE; finish then behaves as in REQ-026.
REQ-034 Macro ENDSTOP_ABORT_EN undefined: no endstop port; motion always runs all N steps.

Verification
REQ-035 num=6, N=6, nn=2, t0=100, tna=60, delta=20, PULSE_W=10 -> 6 pulses, rising-edge spacing 100,80,60,60,80,100; dir=1; finish rises after the last period.
REQ-036 num=-5, N=5, nn=3, t0=100, tna=60, delta=20 -> nn_eff=2; spacing 100,80,60,80,100; dir=0.
REQ-037 N=0 with start -> no pulses; finish=1 two cycles after the start edge; busy high for exactly 1 cycle.
REQ-038 t0=5, tna=5, N=3, PULSE_W=10 -> all periods clamped to 20.
REQ-039 reset asserted during the 3rd pulse high time -> step=0 immediately; busy=0 and finish=0; start held high then produces no motion until it toggles.
REQ-040 With ENDSTOP_ABORT_EN, N=1000, endstop raised after pulse 10 -> no further pulses after at most 3 cycles; finish=1.
